// File: rtl/minmax_queue_pkg.sv
// -----------------------------------------------------------------------------
// minmax_queue_pkg
//   Shared constants and helpers for the min/max priority queue.
//   MODE_MAX / MODE_MIN : values of the MINMAX_ parameter.
//   idx_width()         : width of a slot index for a given slot count.
// -----------------------------------------------------------------------------
package minmax_queue_pkg;

    localparam int MODE_MAX = 0;
    localparam int MODE_MIN = 1;

    // Slot index width; never collapses to zero bits.
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/minmax_queue_select.sv
// -----------------------------------------------------------------------------
// mmq_select
//   Combinational masked selector: finds the slot holding the largest key
//   (MINMAX_ = MODE_MAX) or the smallest key (MINMAX_ = MODE_MIN) among the
//   valid slots. Ties resolve to the lower slot index.
//
//   slot_valid [DEPTH]       in  per-slot valid bits
//   slot_key   [DEPTH][DATA] in  per-slot keys
//   win_idx    [IDX]         out index of the winning slot
//   win_found                out at least one slot is valid
// -----------------------------------------------------------------------------
module mmq_select
    import minmax_queue_pkg::*;
#(
    parameter int MINMAX_ = 0,
    parameter int DEPTH   = 8,
    parameter int DATA    = 8,
    localparam int IDX    = idx_width(DEPTH)
) (
    input  logic [DEPTH-1:0]           slot_valid,
    input  logic [DEPTH-1:0][DATA-1:0] slot_key,
    output logic [IDX-1:0]             win_idx,
    output logic                       win_found
);

    // The valid bit is folded in as the rank MSB so an empty slot can never
    // beat a real key: max ranks {valid,key}, min ranks {~valid,key}.
    function automatic logic [DATA:0] make_rank(input logic v, input logic [DATA-1:0] k);
        return (MINMAX_ == MODE_MIN) ? {~v, k} : {v, k};
    endfunction

    logic [DATA:0] best_rank;
    logic [DATA:0] cand_rank;

    // NOTE: every variable written in a combinational block gets a default at
    // the top, otherwise a path that skips the assignment infers a latch.
    always_comb begin
        win_idx   = '0;
        best_rank = make_rank(slot_valid[0], slot_key[0]);
        cand_rank = '0;
        for (int i = 1; i < DEPTH; i++) begin
            cand_rank = make_rank(slot_valid[i], slot_key[i]);
            // Strict compare: an equal rank keeps the earlier (lower) slot.
            if ((MINMAX_ == MODE_MIN) ? (cand_rank < best_rank)
                                      : (cand_rank > best_rank)) begin
                best_rank = cand_rank;
                win_idx   = IDX'(i);
            end
        end
    end

    assign win_found = |slot_valid;

endmodule

// File: rtl/minmax_queue.sv
// -----------------------------------------------------------------------------
// minmax_queue
//   Priority buffer with valid/ready handshakes on both sides. Entries are
//   written into the lowest free slot; the head (max or min key, lowest slot
//   on ties) is presented combinationally from registered slot state.
//
//   clk                   in  clock
//   reset                 in  synchronous reset, active-high
//   flush                 in  synchronous clear of all entries
//   push_valid/push_ready in/out push handshake (push_ready = ~full)
//   push_key  [DATA]      in  key to insert
//   push_tag  [TAG]       in  payload to insert
//   pop_valid/pop_ready   out/in pop handshake (pop_valid = non-empty)
//   pop_key   [DATA]      out head key, 0 when empty
//   pop_tag   [TAG]       out head payload, 0 when empty
//   count     [CNT]       out number of valid entries
//   full / empty          out count == DEPTH / count == 0
// -----------------------------------------------------------------------------
module minmax_queue
    import minmax_queue_pkg::*;
#(
    parameter int MINMAX_ = 0,
    parameter int DEPTH   = 8,
    parameter int DATA    = 8,
    parameter int TAG     = 4,
    parameter int CNT     = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            push_valid,
    output logic            push_ready,
    input  logic [DATA-1:0] push_key,
    input  logic [TAG-1:0]  push_tag,
    output logic            pop_valid,
    input  logic            pop_ready,
    output logic [DATA-1:0] pop_key,
    output logic [TAG-1:0]  pop_tag,
    output logic [CNT-1:0]  count,
    output logic            full,
    output logic            empty
);

    localparam int IDX = idx_width(DEPTH);

    logic [DEPTH-1:0]           valid_q, valid_d;
    logic [DEPTH-1:0][DATA-1:0] key_q,   key_d;
    logic [DEPTH-1:0][TAG-1:0]  tag_q,   tag_d;
    logic [CNT-1:0]             count_q, count_d;

    logic [IDX-1:0] win_idx;
    logic           win_found;
    logic [IDX-1:0] free_idx;
    logic           free_found;
    logic           push_fire;
    logic           pop_fire;

    // Head selection over the registered slots only, so the pop port never
    // depends on a same-cycle push.
    mmq_select #(
        .MINMAX_ (MINMAX_),
        .DEPTH   (DEPTH),
        .DATA    (DATA)
    ) u_select (
        .slot_valid (valid_q),
        .slot_key   (key_q),
        .win_idx    (win_idx),
        .win_found  (win_found)
    );

    // Lowest free slot: scan from the top so the last hit is the lowest index.
    // Taken from pre-pop state, so a slot popped this cycle is not reused.
    always_comb begin
        free_idx   = '0;
        free_found = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_idx   = IDX'(i);
                free_found = 1'b1;
            end
        end
    end

    assign full       = (count_q == CNT'(DEPTH));
    assign empty      = (count_q == '0);
    assign count      = count_q;
    assign push_ready = ~full;
    assign pop_valid  = win_found;
    assign pop_key    = win_found ? key_q[win_idx] : '0;
    assign pop_tag    = win_found ? tag_q[win_idx] : '0;

    assign push_fire  = push_valid & push_ready;
    assign pop_fire   = pop_valid & pop_ready;

    always_comb begin
        valid_d = valid_q;
        key_d   = key_q;
        tag_d   = tag_q;
        count_d = count_q + CNT'(push_fire) - CNT'(pop_fire);

        if (pop_fire) begin
            valid_d[win_idx] = 1'b0;
        end
        if (push_fire && free_found) begin
            valid_d[free_idx] = 1'b1;
            key_d[free_idx]   = push_key;
            tag_d[free_idx]   = push_tag;
        end

        // Flush wins over push and pop; the concurrent push is dropped.
        if (flush) begin
            valid_d = '0;
            count_d = '0;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples its pre-edge inputs regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    // NOTE: key/tag storage has no reset; a slot's contents are only observed
    // while its valid bit is set, and the outputs are forced to 0 when empty.
    always_ff @(posedge clk) begin
        key_q <= key_d;
        tag_q <= tag_d;
    end

endmodule

// File: tb/tb_minmax_queue.sv
// -----------------------------------------------------------------------------
// tb_minmax_queue
//   Drives a max-mode and a min-mode queue (DEPTH=4) with identical stimulus.
//   A slot-level reference model predicts per-cycle status and the entry each
//   pop must return; a monitor compares whenever the DUT presents output.
// -----------------------------------------------------------------------------
module tb_minmax_queue;

    localparam int DEPTH = 4;
    localparam int DATA  = 8;
    localparam int TAG   = 4;
    localparam int CNT   = 3;

    typedef struct packed {
        logic [CNT-1:0]  count;
        logic            empty;
        logic            full;
        logic            push_ready;
        logic            pop_valid;
        logic [DATA-1:0] key;
        logic [TAG-1:0]  tag;
    } stat_t;

    typedef struct packed {
        logic [DATA-1:0] key;
        logic [TAG-1:0]  tag;
    } entry_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;
    logic push_valid = 1'b0;
    logic pop_ready = 1'b0;
    logic [DATA-1:0] push_key = '0;
    logic [TAG-1:0]  push_tag = '0;

    logic [1:0]           d_push_ready;
    logic [1:0]           d_pop_valid;
    logic [1:0][DATA-1:0] d_pop_key;
    logic [1:0][TAG-1:0]  d_pop_tag;
    logic [1:0][CNT-1:0]  d_count;
    logic [1:0]           d_full;
    logic [1:0]           d_empty;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: per instance (0 = max, 1 = min), slot contents.
    bit              m_valid [2][DEPTH];
    logic [DATA-1:0] m_key   [2][DEPTH];
    logic [TAG-1:0]  m_tag   [2][DEPTH];

    stat_t  stat_q [2][$];
    entry_t pop_q  [2][$];

    always #5 clk = ~clk;

    minmax_queue #(.MINMAX_(0), .DEPTH(DEPTH), .DATA(DATA), .TAG(TAG)) dut_max (
        .clk(clk), .reset(reset), .flush(flush),
        .push_valid(push_valid), .push_ready(d_push_ready[0]),
        .push_key(push_key), .push_tag(push_tag),
        .pop_valid(d_pop_valid[0]), .pop_ready(pop_ready),
        .pop_key(d_pop_key[0]), .pop_tag(d_pop_tag[0]),
        .count(d_count[0]), .full(d_full[0]), .empty(d_empty[0])
    );

    minmax_queue #(.MINMAX_(1), .DEPTH(DEPTH), .DATA(DATA), .TAG(TAG)) dut_min (
        .clk(clk), .reset(reset), .flush(flush),
        .push_valid(push_valid), .push_ready(d_push_ready[1]),
        .push_key(push_key), .push_tag(push_tag),
        .pop_valid(d_pop_valid[1]), .pop_ready(pop_ready),
        .pop_key(d_pop_key[1]), .pop_tag(d_pop_tag[1]),
        .count(d_count[1]), .full(d_full[1]), .empty(d_empty[1])
    );

    task automatic check(input string name, input int act, input int exp, input int m);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s [%s] t=%0t got=%0d expected=%0d",
                     name, (m == 0) ? "max" : "min", $time, act, exp);
        end
    endtask

    function automatic int model_count(input int m);
        int n = 0;
        for (int s = 0; s < DEPTH; s++) n += m_valid[m][s] ? 1 : 0;
        return n;
    endfunction

    // Best key among occupied slots; equal keys keep the lower slot.
    function automatic int model_head(input int m);
        int best = -1;
        for (int s = 0; s < DEPTH; s++) begin
            if (m_valid[m][s]) begin
                if (best < 0) best = s;
                else if ((m == 0) ? (m_key[m][s] > m_key[m][best])
                                  : (m_key[m][s] < m_key[m][best])) best = s;
            end
        end
        return best;
    endfunction

    // One clock of stimulus: drive inputs, queue expectations, advance model.
    task automatic drive(input bit pv, input int k, input int t,
                         input bit pr, input bit fl, input bit rs);
        int head [2];
        int free_slot;
        stat_t  st;
        entry_t e;
        @(negedge clk);
        push_valid = pv;
        push_key   = DATA'(k);
        push_tag   = TAG'(t);
        pop_ready  = pr;
        flush      = fl;
        reset      = rs;
        for (int m = 0; m < 2; m++) begin
            int n = model_count(m);
            head[m]       = model_head(m);
            st.count      = CNT'(n);
            st.empty      = (n == 0);
            st.full       = (n == DEPTH);
            st.push_ready = (n != DEPTH);
            st.pop_valid  = (n != 0);
            st.key        = (n != 0) ? m_key[m][head[m]] : '0;
            st.tag        = (n != 0) ? m_tag[m][head[m]] : '0;
            stat_q[m].push_back(st);
            if (n != 0 && pr) begin
                e.key = m_key[m][head[m]];
                e.tag = m_tag[m][head[m]];
                pop_q[m].push_back(e);
            end
        end
        @(posedge clk);
        for (int m = 0; m < 2; m++) begin
            if (rs || fl) begin
                for (int s = 0; s < DEPTH; s++) m_valid[m][s] = 1'b0;
            end else begin
                free_slot = -1;
                for (int s = DEPTH - 1; s >= 0; s--) if (!m_valid[m][s]) free_slot = s;
                if (pr && head[m] >= 0) m_valid[m][head[m]] = 1'b0;
                if (pv && free_slot >= 0) begin
                    m_valid[m][free_slot] = 1'b1;
                    m_key[m][free_slot]   = DATA'(k);
                    m_tag[m][free_slot]   = TAG'(t);
                end
            end
        end
    endtask

    task automatic push(input int k, input int t);
        drive(1'b1, k, t, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain(input int n);
        repeat (n) drive(1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
    endtask

    // Monitor: status every cycle, popped entry whenever the DUT fires a pop.
    initial begin
        stat_t  st;
        entry_t e;
        forever begin
            @(negedge clk);
            #2;
            for (int m = 0; m < 2; m++) begin
                if (stat_q[m].size() > 0) begin
                    st = stat_q[m].pop_front();
                    check("count",      int'(d_count[m]),      int'(st.count),      m);
                    check("empty",      int'(d_empty[m]),      int'(st.empty),      m);
                    check("full",       int'(d_full[m]),       int'(st.full),       m);
                    check("push_ready", int'(d_push_ready[m]), int'(st.push_ready), m);
                    check("pop_valid",  int'(d_pop_valid[m]),  int'(st.pop_valid),  m);
                    check("head_key",   int'(d_pop_key[m]),    int'(st.key),        m);
                    check("head_tag",   int'(d_pop_tag[m]),    int'(st.tag),        m);
                end
                if (d_pop_valid[m] === 1'b1 && pop_ready === 1'b1) begin
                    if (pop_q[m].size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_pop [%s] t=%0t got key=%0d expected no pop",
                                 (m == 0) ? "max" : "min", $time, d_pop_key[m]);
                    end else begin
                        e = pop_q[m].pop_front();
                        check("pop_key", int'(d_pop_key[m]), int'(e.key), m);
                        check("pop_tag", int'(d_pop_tag[m]), int'(e.tag), m);
                    end
                end
            end
        end
    end

    initial begin
        for (int m = 0; m < 2; m++)
            for (int s = 0; s < DEPTH; s++) begin
                m_valid[m][s] = 1'b0;
                m_key[m][s]   = '0;
                m_tag[m][s]   = '0;
            end

        // Power-on reset, outside the scoreboard since state is undefined.
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // 1: basic ordering, then pop past empty.
        drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        push(5, 1); push(9, 2); push(3, 3);
        drain(5);

        // 2: fill, blocked fifth push, drain.
        push(10, 4); push(20, 5); push(30, 6); push(40, 7);
        drive(1'b1, 50, 8, 1'b0, 1'b0, 1'b0);
        drain(5);

        // 3: simultaneous push and pop.
        push(4, 1); push(6, 2);
        drive(1'b1, 7, 3, 1'b1, 1'b0, 1'b0);
        drain(3);

        // 4: ties resolve by slot, and a zero key is a real entry.
        push(8, 10); push(8, 11);
        drain(3);
        push(0, 12);
        drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
        drain(2);

        // 5: flush with a concurrent push, then reset while full.
        push(1, 1); push(2, 2); push(3, 3);
        drive(1'b1, 99, 9, 1'b1, 1'b1, 1'b0);
        drain(2);
        push(11, 1); push(12, 2); push(13, 3); push(14, 4);
        drive(1'b1, 77, 7, 1'b0, 1'b0, 1'b1);
        drain(2);

        // 6: the min-order case (max instance sees the reverse).
        push(200, 1); push(17, 2); push(255, 3);
        drain(4);

        // Randomized traffic with narrow keys for frequent ties.
        for (int i = 0; i < 600; i++) begin
            int k = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 7) : $urandom_range(0, 255);
            drive(($urandom_range(0, 2) != 0), k, $urandom_range(0, 15),
                  ($urandom_range(0, 1) == 0),
                  ($urandom_range(0, 49) == 0),
                  ($urandom_range(0, 79) == 0));
        end
        drain(6);

        push_valid = 1'b0;
        pop_ready  = 1'b0;
        repeat (3) @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            check("pending_pops", pop_q[m].size(), 0, m);
            check("pending_status", stat_q[m].size(), 0, m);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
